// File: rtl/mor1kx_ctrl_spr_access_cappuccino_pkg.sv
// Shared definitions for the ctrl-stage SPR access engine (mor1kx-defines extension).
package mor1kx_ctrl_spr_access_cappuccino_pkg;

  // Access engine state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } spr_state_e;

  // Default number of BUSY cycles allowed before an access is terminated
  localparam int unsigned SPR_TIMEOUT_DEFAULT = 16;

  // SPR address split into group and index fields
  localparam int unsigned SPR_GROUP_W = 5;
  localparam int unsigned SPR_INDEX_W = 11;

endpackage

// File: rtl/mor1kx_spr_timeout_counter.sv
// Counts BUSY cycles of an SPR access and flags the last cycle before a timeout.
module mor1kx_spr_timeout_counter
  import mor1kx_ctrl_spr_access_cappuccino_pkg::*;
#(
  parameter int unsigned LIMIT = SPR_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT);

  logic [CNT_W-1:0] r_count;

  // Cycle counter; cleared while idle, advanced while an access is in flight
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired_c = (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mor1kx_ctrl_spr_access_cappuccino.sv
// Ctrl-stage mfspr/mtspr responder: runs one SPR bus transaction per op and
// returns the ack that releases the ctrl-stage stall.
module mor1kx_ctrl_spr_access_cappuccino
  import mor1kx_ctrl_spr_access_cappuccino_pkg::*;
#(
  parameter int unsigned OPTION_OPERAND_WIDTH  = 32,
  parameter int unsigned OPTION_SPR_ADDR_WIDTH = 16,
  parameter int unsigned SPR_TIMEOUT           = SPR_TIMEOUT_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ctrl_op_mfspr_i,
  input  logic                             ctrl_op_mtspr_i,
  input  logic [OPTION_SPR_ADDR_WIDTH-1:0] ctrl_spr_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  ctrl_rfb_i,
  input  logic                             padv_ctrl_i,
  input  logic                             pipeline_flush_i,
  output logic                             spr_bus_stb_o,
  output logic                             spr_bus_we_o,
  output logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_addr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_i,
  input  logic                             spr_bus_ack_i,
  output logic                             ctrl_mfspr_ack_o,
  output logic                             ctrl_mtspr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]  mfspr_dat_o,
  output logic                             spr_timeout_o
);

  spr_state_e                       r_state;
  logic                             r_stb;
  logic                             r_we;
  logic [OPTION_SPR_ADDR_WIDTH-1:0] r_addr;
  logic [OPTION_OPERAND_WIDTH-1:0]  r_dat;
  logic [OPTION_OPERAND_WIDTH-1:0]  r_rdat;
  logic                             r_mfspr_ack;
  logic                             r_mtspr_ack;
  logic                             r_timeout;
  logic                             r_flush_seen;

  logic w_expired;
  logic w_op;
  logic w_flush_any;
  logic w_finish;

  assign w_op        = ctrl_op_mfspr_i | ctrl_op_mtspr_i;
  assign w_flush_any = r_flush_seen | pipeline_flush_i;
  assign w_finish    = spr_bus_ack_i | w_expired;

  mor1kx_spr_timeout_counter #(
    .LIMIT (SPR_TIMEOUT)
  ) u_timeout_counter (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (r_state == ST_IDLE),
    .i_enable    (r_state == ST_BUSY),
    .o_expired_c (w_expired)
  );

  // Access FSM with its bus-side and ctrl-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_dat        <= '0;
      r_rdat       <= '0;
      r_mfspr_ack  <= 1'b0;
      r_mtspr_ack  <= 1'b0;
      r_timeout    <= 1'b0;
      r_flush_seen <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_op && !pipeline_flush_i) begin
            r_stb        <= 1'b1;
            r_we         <= ctrl_op_mtspr_i;
            r_addr       <= ctrl_spr_addr_i;
            r_dat        <= ctrl_rfb_i;
            r_flush_seen <= 1'b0;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A flush never aborts the bus cycle; it only suppresses the ack
          if (pipeline_flush_i) begin
            r_flush_seen <= 1'b1;
          end
          if (w_finish) begin
            r_stb     <= 1'b0;
            r_timeout <= !spr_bus_ack_i;
            if (!r_we) begin
              r_rdat <= spr_bus_ack_i ? spr_bus_dat_i : '0;
            end
            if (w_flush_any) begin
              r_state <= ST_DRAIN;
            end else begin
              r_mfspr_ack <= !r_we;
              r_mtspr_ack <= r_we;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Hold the ack until the ctrl stage moves on
          if (padv_ctrl_i || pipeline_flush_i) begin
            r_mfspr_ack <= 1'b0;
            r_mtspr_ack <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spr_bus_stb_o    = r_stb;
  assign spr_bus_we_o     = r_we;
  assign spr_bus_addr_o   = r_addr;
  assign spr_bus_dat_o    = r_dat;
  assign ctrl_mfspr_ack_o = r_mfspr_ack;
  assign ctrl_mtspr_ack_o = r_mtspr_ack;
  assign mfspr_dat_o      = r_rdat;
  assign spr_timeout_o    = r_timeout;

endmodule
